// File: rtl/scalar_bit_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : scalar_bit_sequencer_if
// Description : Control and bit-stream handshake bundle between the scalar
//               load path, the bit sequencer and the ladder datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface scalar_bit_sequencer_if #(
    parameter int N  = 255,
    parameter int IW = $clog2(N)
);
    logic          start;
    logic [N-1:0]  scalar;
    logic          abort;
    logic          busy;
    logic          bit_valid;
    logic          bit_ready;
    logic          bit_out;
    logic [IW-1:0] bit_idx;
    logic          first;
    logic          last;
    logic          done;
    logic          zero_err;

    // Requester / consumer side
    modport master (
        output start, scalar, abort, bit_ready,
        input  busy, bit_valid, bit_out, bit_idx, first, last, done, zero_err
    );

    // Sequencer side
    modport slave (
        input  start, scalar, abort, bit_ready,
        output busy, bit_valid, bit_out, bit_idx, first, last, done, zero_err
    );
endinterface
`default_nettype wire

// File: rtl/scalar_bit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scalar_bit_sequencer
// Description : Streams the significant bits of a scalar, MSB first, one bit
//               per valid/ready beat, framed with first/last/done.
//               Contains the priority encoder used to locate the MSB.
// Revision    : 1.0 - initial release
// ============================================================================

// Returns the index of the highest set bit of n; 0 when n==0 or en==0.
module priority_encode #(
    parameter int N  = 255,
    parameter int IW = $clog2(N)
) (
    input  wire logic          en,
    input  wire logic [N-1:0]  n,
    output logic      [IW-1:0] idx
);
    // Ascending scan so the highest set bit is the last one to win
    always_comb begin
        idx = '0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                if (n[i]) idx = IW'(i);
            end
        end
    end
endmodule

module scalar_bit_sequencer #(
    parameter int N  = 255,
    parameter int IW = $clog2(N)
) (
    input wire logic             clk,
    input wire logic             rst_n,
    scalar_bit_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIND = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  sc_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] msb_q;
    logic [IW-1:0] msb;
    logic          zero_err_q;
    logic          xfer;
    logic          busy;
    logic          bit_valid;
    logic          done;

    priority_encode #(.N(N), .IW(IW)) u_penc (
        .en  (1'b1),
        .n   (sc_q),
        .idx (msb)
    );

    // A beat is consumed whenever the sequencer presents one and the ladder takes it
    assign xfer = (state == S_RUN) && bus.bit_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Scalar, index and error bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sc_q       <= '0;
            idx_q      <= '0;
            msb_q      <= '0;
            zero_err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        sc_q       <= bus.scalar;
                        zero_err_q <= 1'b0;
                    end
                end
                S_FIND: begin
                    if (!bus.abort) begin
                        idx_q <= msb;
                        msb_q <= msb;
                        // Encoder output is ambiguous for zero, so test the operand itself
                        if (!(|sc_q)) zero_err_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Index holds at 0 on the final beat rather than wrapping
                    if (xfer && !bus.abort && (idx_q != '0)) idx_q <= idx_q - IW'(1);
                end
                default: ;
            endcase
        end
    end

    // Next-state and framing outputs; none depend on bit_ready
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        bit_valid = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start && !bus.abort) state_nxt = S_FIND;
            end
            S_FIND: begin
                busy      = 1'b1;
                state_nxt = (|sc_q) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                if (xfer && (idx_q == '0)) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (bus.abort && (state != S_IDLE)) state_nxt = S_IDLE;
    end

    assign bus.busy      = busy;
    assign bus.bit_valid = bit_valid;
    assign bus.done      = done;
    assign bus.bit_idx   = idx_q;
    assign bus.bit_out   = bit_valid && sc_q[idx_q];
    assign bus.first     = bit_valid && (idx_q == msb_q);
    assign bus.last      = bit_valid && (idx_q == '0);
    assign bus.zero_err  = zero_err_q;
endmodule
`default_nettype wire

// File: tb/tb_scalar_bit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scalar_bit_sequencer
// Description : Directed self-checking bench for scalar_bit_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scalar_bit_sequencer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    scalar_bit_sequencer_if bus ();

    scalar_bit_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.start  = 1'b1;
        bus.scalar = 255'd7;
        bus.abort  = 1'b0;
        bus.bit_ready = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({bus.busy, bus.bit_valid, bus.bit_out, bus.first, bus.last, bus.done, bus.zero_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {bus.busy, bus.bit_valid, bus.bit_out, bus.first, bus.last, bus.done, bus.zero_err});
        end
        n_cmp++;
        if (bus.bit_idx !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_idx: got %0d want 0", bus.bit_idx);
        end
        bus.start = 1'b0;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_zero();
        bus.scalar = '0;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.bit_valid !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_find: busy/valid/done got %b%b%b want 100", bus.busy, bus.bit_valid, bus.done);
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b1 || bus.zero_err !== 1'b1 || bus.bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: done/zero_err/valid got %b%b%b want 110", bus.done, bus.zero_err, bus.bit_valid);
        end
        tick(); tick();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.zero_err !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_hold: done/busy/zero_err got %b%b%b want 001", bus.done, bus.busy, bus.zero_err);
        end
    endtask

    // Full run with ready held high; expected beats come from the bench's own scalar
    task automatic test_run(input logic [254:0] s, input int msb, input string name);
        bus.scalar    = s;
        bus.bit_ready = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.bit_valid !== 1'b0 || bus.zero_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_find: busy/valid/zero_err got %b%b%b want 100", name, bus.busy, bus.bit_valid, bus.zero_err);
        end
        tick();
        for (int i = msb; i >= 0; i--) begin
            n_cmp++;
            if (bus.bit_valid !== 1'b1 || bus.bit_idx !== 8'(i) || bus.bit_out !== s[i] ||
                bus.first !== (i == msb) || bus.last !== (i == 0) || bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_beat: got v=%b idx=%0d bit=%b f=%b l=%b d=%b want v=1 idx=%0d bit=%b f=%b l=%b d=0",
                         name, bus.bit_valid, bus.bit_idx, bus.bit_out, bus.first, bus.last, bus.done,
                         i, s[i], (i == msb), (i == 0));
            end
            tick();
        end
        n_cmp++;
        if (bus.done !== 1'b1 || bus.bit_valid !== 1'b0 || bus.zero_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: done/valid/zero_err got %b%b%b want 100", name, bus.done, bus.bit_valid, bus.zero_err);
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end: done/busy got %b%b want 00", name, bus.done, bus.busy);
        end
    endtask

    task automatic test_stall();
        logic [254:0] s;
        s = 255'h0;
        s[31:0] = 32'hFFFF_FFFF;
        bus.scalar    = s;
        bus.bit_ready = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        for (int i = 31; i >= 0; i--) begin
            n_cmp++;
            if (bus.bit_valid !== 1'b1 || bus.bit_idx !== 8'(i) || bus.bit_out !== 1'b1 ||
                bus.first !== (i == 31) || bus.last !== (i == 0)) begin
                n_fail++;
                $display("FAIL stall_beat: got v=%b idx=%0d bit=%b f=%b l=%b want v=1 idx=%0d bit=1 f=%b l=%b",
                         bus.bit_valid, bus.bit_idx, bus.bit_out, bus.first, bus.last, i, (i == 31), (i == 0));
            end
            if (i == 17) begin
                bus.bit_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    // Mid-run start with a scalar whose bit 16 is clear
                    bus.start  = (k == 0);
                    bus.scalar = 255'd5;
                    tick();
                    n_cmp++;
                    if (bus.bit_valid !== 1'b1 || bus.bit_idx !== 8'd17 || bus.bit_out !== 1'b1 ||
                        bus.first !== 1'b0 || bus.last !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_hold: got v=%b idx=%0d bit=%b f=%b l=%b want v=1 idx=17 bit=1 f=0 l=0",
                                 bus.bit_valid, bus.bit_idx, bus.bit_out, bus.first, bus.last);
                    end
                end
                bus.start     = 1'b0;
                bus.bit_ready = 1'b1;
            end
            tick();
        end
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done: done got %b want 1", bus.done);
        end
        tick();
    endtask

    // Interrupt an all-ones run at idx 100 with abort (use_rst=0) or reset (use_rst=1)
    task automatic test_interrupt(input bit use_rst, input string name);
        int guard;
        bus.scalar    = '1;
        bus.bit_ready = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        guard = 0;
        while (bus.bit_idx !== 8'd100 || bus.bit_valid !== 1'b1) begin
            tick();
            guard++;
            if (guard > 300) break;
        end
        n_cmp++;
        if (guard > 300) begin
            n_fail++;
            $display("FAIL %s_reach100: idx got %0d want 100", name, bus.bit_idx);
        end
        if (use_rst) rst_n = 1'b0;
        else         bus.abort = 1'b1;
        tick();
        rst_n     = 1'b1;
        bus.abort = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.bit_valid !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_stop: busy/valid/done got %b%b%b want 000", name, bus.busy, bus.bit_valid, bus.done);
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_nodone: done/busy got %b%b want 00", name, bus.done, bus.busy);
        end
        test_run(255'd2, 1, {name, "_s2"});
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_zero();
        test_run(255'd1, 0, "one");
        test_run(255'd5, 2, "five");
        test_run('1, 254, "ones");
        test_stall();
        test_interrupt(1'b0, "abort");
        test_interrupt(1'b1, "rstmid");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
